// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem req/ack
// handshake and hands fetched words to decode.
module fetch_ctrl #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              addr_err
);

  typedef enum logic [1:0] {
    BOOT,
    REQ,
    VALID,
    FLUSH
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] pc_n;
  logic [ADDR_W-1:0] addr_n;
  logic [ADDR_W-1:0] instr_pc_n;
  logic [31:0]       instr_n;
  logic              valid_n;
  logic              err_n;
  logic [ADDR_W-1:0] tgt;

  assign tgt = {redirect_target[ADDR_W-1:2], 2'b00};

  assign imem_req = (state == REQ) || (state == FLUSH);

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state       <= BOOT;
      pc          <= RESET_VEC;
      imem_addr   <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      addr_err    <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      imem_addr   <= addr_n;
      instr_valid <= valid_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      addr_err    <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    addr_n     = imem_addr;
    valid_n    = instr_valid;
    instr_n    = instr;
    instr_pc_n = instr_pc;
    err_n      = redirect_valid && (redirect_target[1:0] != 2'b00);
    unique case (state)
      BOOT: begin
        state_n = REQ;
        if (redirect_valid) begin
          pc_n   = tgt;
          addr_n = tgt;
        end else begin
          addr_n = pc;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          pc_n = tgt;
          if (imem_ack) begin
            addr_n = tgt;
          end else begin
            state_n = FLUSH;
          end
        end else if (imem_ack) begin
          instr_n    = imem_rdata;
          instr_pc_n = imem_addr;
          valid_n    = 1'b1;
          pc_n       = pc + ADDR_W'(4);
          state_n    = VALID;
        end
      end
      VALID: begin
        if (redirect_valid) begin
          valid_n = 1'b0;
          pc_n    = tgt;
          addr_n  = tgt;
          state_n = REQ;
        end else if (!stall) begin
          valid_n = 1'b0;
          addr_n  = pc;
          state_n = REQ;
        end
      end
      FLUSH: begin
        // Old request must still complete; its data is dropped.
        if (redirect_valid) begin
          pc_n = tgt;
        end
        if (imem_ack) begin
          addr_n  = redirect_valid ? tgt : pc;
          state_n = REQ;
        end
      end
      default: state_n = BOOT;
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a small latency-programmable
// instruction memory model.
module tb_fetch_ctrl;

  localparam int ADDR_W = 32;
  localparam logic [31:0] KEY = 32'hC0DE0000;

  logic        clock;
  logic        nreset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc;
  logic        addr_err;

  int checks = 0;
  int errors = 0;

  int   lat;
  int   cnt;
  logic mem_en;
  logic force_ack;

  fetch_ctrl #(
    .ADDR_W(ADDR_W),
    .RESET_VEC(32'h100)
  ) dut (
    .clock(clock),
    .nreset(nreset),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
    .pc(pc),
    .addr_err(addr_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always_comb begin
    imem_ack   = mem_en ? (imem_req && (cnt >= lat)) : force_ack;
    imem_rdata = imem_addr ^ KEY;
  end

  always @(posedge clock) begin
    if (!imem_req || imem_ack) cnt <= 0;
    else cnt <= cnt + 1;
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    tick();
    tick();
    checks++;
    if ({imem_req, instr_valid, addr_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000",
               {imem_req, instr_valid, addr_err});
    end
    checks++;
    if (pc !== 32'h100) begin
      errors++;
      $display("FAIL reset_pc got %h exp 00000100", pc);
    end
    checks++;
    if ({imem_addr, instr, instr_pc} !== 96'h0) begin
      errors++;
      $display("FAIL reset_regs got %h %h %h exp 0",
               imem_addr, instr, instr_pc);
    end
  endtask

  task automatic test_boot_seq();
    logic [31:0] a;
    nreset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = 32'h100 + 32'(4 * k);
      tick();
      checks++;
      if ({imem_req, instr_valid, imem_addr} !== {2'b10, a}) begin
        errors++;
        $display("FAIL boot_req%0d got %b%b %h exp 10 %h",
                 k, imem_req, instr_valid, imem_addr, a);
      end
      tick();
      checks++;
      if ({imem_req, instr_valid, instr_pc, instr}
          !== {2'b01, a, a ^ KEY}) begin
        errors++;
        $display("FAIL boot_valid%0d got %b%b %h %h exp 01 %h %h",
                 k, imem_req, instr_valid, instr_pc, instr, a, a ^ KEY);
      end
    end
    tick();
  endtask

  task automatic test_delay();
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    tick();
    redirect_valid = 1'b0;
    lat = 3;
    checks++;
    if ({instr_valid, instr_pc, imem_addr} !== {1'b0, 32'h108, 32'h200}) begin
      errors++;
      $display("FAIL redir_ack_same got %b %h %h exp 0 108 200",
               instr_valid, instr_pc, imem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({imem_req, instr_valid, imem_addr} !== {2'b10, 32'h200}) begin
        errors++;
        $display("FAIL delay_wait%0d got %b%b %h exp 10 200",
                 i, imem_req, instr_valid, imem_addr);
      end
    end
    tick();
    checks++;
    if ({instr_valid, instr_pc, pc} !== {1'b1, 32'h200, 32'h204}) begin
      errors++;
      $display("FAIL delay_valid got %b %h %h exp 1 200 204",
               instr_valid, instr_pc, pc);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) force_ack = 1'b1;
      mem_en = (i != 2);
      tick();
      checks++;
      if ({imem_req, instr_valid, instr_pc, instr}
          !== {2'b01, 32'h200, 32'h200 ^ KEY}) begin
        errors++;
        $display("FAIL stall_hold%0d got %b%b %h %h exp 01 200 %h",
                 i, imem_req, instr_valid, instr_pc, instr, 32'h200 ^ KEY);
      end
    end
    force_ack = 1'b0;
    mem_en    = 1'b1;
    stall     = 1'b0;
    lat       = 0;
    tick();
    checks++;
    if ({imem_req, instr_valid, imem_addr} !== {2'b10, 32'h204}) begin
      errors++;
      $display("FAIL stall_next got %b%b %h exp 10 204",
               imem_req, instr_valid, imem_addr);
    end
    tick();
  endtask

  task automatic test_flush();
    redirect_valid  = 1'b1;
    redirect_target = 32'h104;
    lat = 2;
    tick();
    redirect_target = 32'h400;
    checks++;
    if (imem_addr !== 32'h104) begin
      errors++;
      $display("FAIL flush_req got %h exp 104", imem_addr);
    end
    tick();
    redirect_valid = 1'b0;
    checks++;
    if ({imem_req, instr_valid, imem_addr, pc}
        !== {2'b10, 32'h104, 32'h400}) begin
      errors++;
      $display("FAIL flush_enter got %b%b %h %h exp 10 104 400",
               imem_req, instr_valid, imem_addr, pc);
    end
    tick();
    checks++;
    if ({imem_req, instr_valid, imem_addr, imem_ack}
        !== {2'b10, 32'h104, 1'b1}) begin
      errors++;
      $display("FAIL flush_ack got %b%b %h %b exp 10 104 1",
               imem_req, instr_valid, imem_addr, imem_ack);
    end
    tick();
    lat = 0;
    checks++;
    if ({imem_req, instr_valid, imem_addr} !== {2'b10, 32'h400}) begin
      errors++;
      $display("FAIL flush_exit got %b%b %h exp 10 400",
               imem_req, instr_valid, imem_addr);
    end
    tick();
    checks++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h400, 32'h400 ^ KEY}) begin
      errors++;
      $display("FAIL flush_valid got %b %h %h exp 1 400 %h",
               instr_valid, instr_pc, instr, 32'h400 ^ KEY);
    end
  endtask

  task automatic test_misaligned();
    stall           = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h402;
    tick();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    checks++;
    if ({instr_valid, addr_err, imem_req, imem_addr, pc}
        !== {3'b011, 32'h400, 32'h400}) begin
      errors++;
      $display("FAIL misalign_kill got %b%b%b %h %h exp 011 400 400",
               instr_valid, addr_err, imem_req, imem_addr, pc);
    end
    tick();
    checks++;
    if ({instr_valid, addr_err, instr_pc} !== {2'b10, 32'h400}) begin
      errors++;
      $display("FAIL misalign_after got %b%b %h exp 10 400",
               instr_valid, addr_err, instr_pc);
    end
  endtask

  task automatic test_wrap();
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if ({imem_addr, pc} !== {32'hFFFF_FFFC, 32'hFFFF_FFFC}) begin
      errors++;
      $display("FAIL wrap_req got %h %h exp fffffffc fffffffc",
               imem_addr, pc);
    end
    tick();
    checks++;
    if ({instr_valid, instr_pc, pc} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
      errors++;
      $display("FAIL wrap_pc got %b %h %h exp 1 fffffffc 0",
               instr_valid, instr_pc, pc);
    end
    tick();
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL wrap_next got %b %h exp 1 0", imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    lat = 5;
    tick();
    checks++;
    if ({imem_req, imem_ack, instr_valid} !== 3'b100) begin
      errors++;
      $display("FAIL mid_pending got %b%b%b exp 100",
               imem_req, imem_ack, instr_valid);
    end
    nreset = 1'b0;
    tick();
    checks++;
    if ({imem_req, instr_valid, addr_err, imem_addr, instr, instr_pc, pc}
        !== {3'b000, 96'h0, 32'h100}) begin
      errors++;
      $display("FAIL mid_reset got %b%b%b %h %h %h %h exp 000 0 0 0 100",
               imem_req, instr_valid, addr_err, imem_addr, instr,
               instr_pc, pc);
    end
    nreset    = 1'b1;
    mem_en    = 1'b0;
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    mem_en    = 1'b1;
    lat       = 0;
    checks++;
    if ({imem_req, instr_valid, instr, imem_addr}
        !== {2'b10, 32'h0, 32'h100}) begin
      errors++;
      $display("FAIL mid_late_ack got %b%b %h %h exp 10 0 100",
               imem_req, instr_valid, instr, imem_addr);
    end
    tick();
    checks++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h100, 32'h100 ^ KEY}) begin
      errors++;
      $display("FAIL mid_refetch got %b %h %h exp 1 100 %h",
               instr_valid, instr_pc, instr, 32'h100 ^ KEY);
    end
  endtask

  initial begin
    nreset          = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    lat             = 0;
    mem_en          = 1'b1;
    force_ack       = 1'b0;
    test_reset();
    test_boot_seq();
    test_delay();
    test_stall();
    test_flush();
    test_misaligned();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the RISC-V core. It owns the program counter and drives the instruction-memory request/acknowledge handshake. It presents each fetched instruction to decode with its PC, honours decode stalls, and applies branch/jump redirects from execute. Outstanding memory requests are always completed; on a redirect their data is discarded.

Parameters:
ADDR_W, 32, width of PC and instruction address
RESET_VEC, 0, PC value loaded on reset (bits [1:0] must be 0)

Ports:
clock  input  1  system clock, all state on rising edge
nreset  input  1  synchronous active-low reset
stall  input  1  decode cannot accept; instr held while high
redirect_valid  input  1  taken branch/jump this cycle
redirect_target  input  ADDR_W  new PC for redirect
imem_req  output  1  fetch request to instruction memory
imem_addr  output  ADDR_W  fetch address, stable while imem_req high
imem_ack  input  1  memory returns imem_rdata this cycle (latency >= 0 cycles after req)
imem_rdata  input  32  fetched instruction word
instr_valid  output  1  instr/instr_pc valid for decode
instr  output  32  fetched instruction
instr_pc  output  ADDR_W  address of instr
pc  output  ADDR_W  next PC to fetch
addr_err  output  1  one-cycle pulse: redirect_target[1:0] != 0

Behaviour:
- Clock is clock; reset is synchronous, active-low (nreset). It is sampled only on the rising edge and overrides everything.
- Reset values: state=BOOT, pc=RESET_VEC, imem_addr=0, imem_req=0, instr_valid=0, instr=0, instr_pc=0, addr_err=0.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- States: BOOT, REQ, VALID, FLUSH.
- BOOT:
  - next cycle -> REQ, latching imem_addr=pc.
  - imem_ack is ignored.
- REQ: imem_req=1 and imem_addr stays stable until imem_ack.
  - On imem_ack with no redirect: instr<=imem_rdata, instr_pc<=imem_addr, instr_valid<=1, pc<=pc+4, -> VALID.
- VALID: instr_valid=1, imem_req=0.
  - stall=1: hold instr/instr_pc/instr_valid unchanged, stay.
  - stall=0: instr is consumed this cycle; -> REQ with imem_addr=pc, instr_valid<=0.
  - Peak throughput is one instruction per 2 cycles (zero-wait memory).
- FLUSH: imem_req=1 with the old imem_addr until imem_ack. The ack data is discarded. Then -> REQ with imem_addr=pc.
- Redirect has priority over every other event in the same cycle. Effective target is {redirect_target[ADDR_W-1:2],2'b00}; addr_err<=1 for one cycle if redirect_target[1:0]!=0.
  - BOOT: pc<=target, -> REQ with imem_addr=target.
  - REQ, no ack this cycle: pc<=target, -> FLUSH. The request is not abandoned.
  - REQ, ack same cycle: data discarded, instr_valid stays 0, pc<=target, -> REQ with imem_addr=target.
  - VALID: instr_valid<=0 (instruction killed even if stall=1), pc<=target, -> REQ with imem_addr=target.
  - FLUSH: pc<=target (latest redirect wins), stay FLUSH until ack.
- PC arithmetic is modulo 2^ADDR_W: pc = 2^ADDR_W-4 increments to 0. No carry out.
- imem_ack outside REQ/FLUSH is ignored and has no effect on any output.
- Reset mid-request: the next state is BOOT. Any later ack for the abandoned request arrives in BOOT and is ignored. The memory side must not ack after seeing imem_req=0.

Test Plan:
- Reset/boot, RESET_VEC=0x100, zero-wait memory (ack in the same cycle as req), stall=0 -> imem_addr sequence 0x100,0x104,0x108; instr_pc matches each; instr_valid high every other cycle.
- Memory ack delayed 3 cycles at addr 0x200 -> imem_req and imem_addr=0x200 stable for 3 cycles; instr_valid rises only the cycle after ack.
- stall=1 for 4 cycles while VALID -> instr/instr_pc unchanged, imem_req=0 throughout; next fetch is 0x204 after stall drops.
- Redirect to 0x400 one cycle after req issued to 0x104 with ack 2 cycles later -> FLUSH; 0x104 data never appears on instr; next request at 0x400; instr_pc=0x400.
- Redirect to 0x402 while VALID with stall=1 -> instr_valid drops next cycle, addr_err pulses once, next imem_addr=0x400.
- pc=0xFFFFFFFC (ADDR_W=32) fetched -> pc becomes 0x00000000. Separately, nreset=0 during an outstanding request -> all outputs return to reset values on the next edge, and a late ack has no effect.
